music_note_player: RTL and testbench

// Consumer side of the music address counter: drives the counter's advance strobe and segment mode, samples
// the melody ROM word at each counter address, and plays it as a square-wave buzzer tone for a beat-timed duration.

---
 rtl/music_note_player_if.sv | 25 ++
 rtl/music_note_player.sv | 147 ++++++++++++++
 tb/tb_music_note_player.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/music_note_player_if.sv
// Control/bus bundle between game control, address counter / melody ROM and the note player.
// master = game control plus counter/ROM side, slave = music_note_player.
interface music_note_player_if;
    logic        play;
    logic        stop;
    logic [2:0]  seg_sel;
    logic        addr_finish;
    logic [15:0] rom_data;
    logic        addr_en;
    logic [30:0] mode;
    logic        buzzer;
    logic [15:0] note;
    logic        busy;
    logic        done;

    modport master (
        output play, stop, seg_sel, addr_finish, rom_data,
        input  addr_en, mode, buzzer, note, busy, done
    );

    modport slave (
        input  play, stop, seg_sel, addr_finish, rom_data,
        output addr_en, mode, buzzer, note, busy, done
    );
endinterface

// File: rtl/music_note_player.sv
// Melody player: primes the address counter, fetches ROM words and plays each as a beat-timed square-wave tone.
// Define LOOP_PLAY_EN to add a loop input that restarts the segment instead of finishing.
module music_note_player #(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int TICK_DIV    = 50,
    parameter int ROM_LAT     = 1
) (
    input  logic clk,
    input  logic rst,
`ifdef LOOP_PLAY_EN
    input  logic loop,
`endif
    music_note_player_if.slave bus
);
    localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [1:0]        FETCH_LAST = 2'(ROM_LAT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRIME = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic              r_prime_cnt;
    logic [1:0]        r_fetch_cnt;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [3:0]        r_beat_idx;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [11:0]       r_half_cnt;
    logic              r_last_flag;
    logic              r_buzzer;
    logic [15:0]       r_note;
    logic [2:0]        r_mode;

    logic w_loop;
    logic w_play_last;
    logic w_half_last;

`ifdef LOOP_PLAY_EN
    assign w_loop = loop;
`else
    assign w_loop = 1'b0;
`endif

    assign w_play_last = (r_state == S_PLAY) && (r_beat_cnt == BEAT_LAST)
                         && (r_beat_idx == r_note[15:12]);
    assign w_half_last = (r_half_cnt == (r_note[11:0] - 12'd1));

    // The in-play advance strobe lands on the final PLAY cycle so the next fetch overlaps nothing.
    assign bus.addr_en = (r_state == S_PRIME) || (w_play_last && !r_last_flag);
    assign bus.mode    = {28'd0, r_mode};
    assign bus.buzzer  = r_buzzer;
    assign bus.note    = r_note;
    assign bus.busy    = (r_state == S_PRIME) || (r_state == S_FETCH) || (r_state == S_PLAY);
    assign bus.done    = (r_state == S_DONE);

    // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_prime_cnt <= 1'b0;
            r_fetch_cnt <= 2'd0;
            r_beat_cnt  <= '0;
            r_beat_idx  <= 4'd0;
            r_tick_cnt  <= '0;
            r_half_cnt  <= 12'd0;
            r_last_flag <= 1'b0;
            r_buzzer    <= 1'b0;
            r_note      <= 16'd0;
            r_mode      <= 3'd0;
        end else if (bus.stop) begin
            r_state  <= S_IDLE;
            r_buzzer <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.play) begin
                        r_mode      <= bus.seg_sel;
                        r_prime_cnt <= 1'b0;
                        r_state     <= S_PRIME;
                    end
                end
                S_PRIME: begin
                    r_prime_cnt <= 1'b1;
                    if (r_prime_cnt) begin
                        r_fetch_cnt <= 2'd0;
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (r_fetch_cnt == FETCH_LAST) begin
                        r_note      <= bus.rom_data;
                        r_last_flag <= bus.addr_finish;
                        r_beat_cnt  <= '0;
                        r_beat_idx  <= 4'd0;
                        r_tick_cnt  <= '0;
                        r_half_cnt  <= 12'd0;
                        r_buzzer    <= 1'b0;
                        r_state     <= S_PLAY;
                    end else begin
                        r_fetch_cnt <= r_fetch_cnt + 2'd1;
                    end
                end
                S_PLAY: begin
                    if (w_play_last) begin
                        r_buzzer <= 1'b0;
                        if (!r_last_flag) begin
                            r_fetch_cnt <= 2'd0;
                            r_state     <= S_FETCH;
                        end else if (w_loop) begin
                            r_prime_cnt <= 1'b0;
                            r_state     <= S_PRIME;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        if (r_beat_cnt == BEAT_LAST) begin
                            r_beat_cnt <= '0;
                            r_beat_idx <= r_beat_idx + 4'd1;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= '0;
                            // A zero half-period is a rest: the tone never toggles.
                            if (r_note[11:0] != 12'd0) begin
                                if (w_half_last) begin
                                    r_half_cnt <= 12'd0;
                                    r_buzzer   <= ~r_buzzer;
                                end else begin
                                    r_half_cnt <= r_half_cnt + 12'd1;
                                end
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_music_note_player.sv
// Scoreboard bench for music_note_player with a behavioural address-counter / melody-ROM model.
// Honours LOOP_PLAY_EN when defined (adds a segment-loop scenario).
module tb_music_note_player;
    localparam int BEAT_CYCLES = 8;
    localparam int TICK_DIV    = 2;
    localparam int ROM_LAT     = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    music_note_player_if bus ();
`ifdef LOOP_PLAY_EN
    logic loop = 1'b0;
`endif

    music_note_player #(
        .BEAT_CYCLES(BEAT_CYCLES),
        .TICK_DIV   (TICK_DIV),
        .ROM_LAT    (ROM_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
`ifdef LOOP_PLAY_EN
        .loop(loop),
`endif
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Address counter + ROM model: 1st pulse latches bounds, 2nd loads start, later pulses advance.
    logic [15:0] rom [64];
    int seg_start [8];
    int seg_end   [8];
    int addr = 0, step = 0, cur_seg = 0;
    bit ctr_restart = 1'b0;

    assign bus.addr_finish = (step == 2) && (addr == seg_end[cur_seg]);

    always @(posedge clk) begin
        bus.rom_data <= rom[addr];
        if (ctr_restart) begin
            step <= 0;
        end else if (bus.addr_en) begin
            if (step == 0 || (step == 2 && addr == seg_end[cur_seg])) begin
                cur_seg <= int'(bus.mode[2:0]);
                step    <= 1;
            end else if (step == 1) begin
                addr <= seg_start[cur_seg];
                step <= 2;
            end else begin
                addr <= addr + 1;
            end
        end
    end

    typedef struct {
        logic [15:0] word;
        bit          last;
    } exp_t;

    exp_t sb [$];

    function automatic logic exp_buzz(input logic [15:0] w, input int t);
        int half;
        half = int'(w[11:0]);
        if (half == 0) return 1'b0;
        return ((t / (half * TICK_DIV)) % 2) == 1;
    endfunction

    // Monitor: a note starts ROM_LAT+2 cycles after the last addr_en cycle.
    int   cyc = 0;
    int   last_en = -100;
    int   t = 0;
    int   mism = 0;
    bit   in_note = 1'b0;
    exp_t cur;

    task automatic end_note(input bit by_state);
        check("note_len", t, (cur.word[15:12] + 1) * BEAT_CYCLES);
        check("tone", mism, 0);
        if (by_state) begin
            check("end_kind", 1, 32'(cur.last));
            if (!bus.busy) begin
                check("done_flag", {31'd0, bus.done}, 1);
                check("hold_note", {16'd0, bus.note}, {16'd0, cur.word});
                check("done_buzzer", {31'd0, bus.buzzer}, 0);
            end
        end
        in_note = 1'b0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst || bus.stop) begin
            in_note = 1'b0;
            last_en = -100;
            sb.delete();
        end else begin
            if (!in_note && bus.busy && cyc == last_en + ROM_LAT + 2) begin
                if (sb.size() == 0) begin
                    check("sb_size", 32'(sb.size()), 1);
                end else begin
                    cur = sb.pop_front();
                    check("note_word", {16'd0, bus.note}, {16'd0, cur.word});
                    in_note = 1'b1;
                    t = 0;
                    mism = 0;
                end
            end
            if (in_note) begin
                if (!bus.busy || (bus.addr_en && cur.last)) begin
                    end_note(1'b1);
                end else begin
                    if (bus.buzzer !== exp_buzz(cur.word, t)) mism++;
                    t++;
                    if (bus.addr_en) end_note(1'b0);
                end
            end else if (bus.busy) begin
                check("gap_buzzer", {31'd0, bus.buzzer}, 0);
            end
            if (bus.addr_en) last_en = cyc;
        end
    end

    task automatic push_seg(input int s);
        for (int a = seg_start[s]; a <= seg_end[s]; a++) sb.push_back('{rom[a], a == seg_end[s]});
    endtask

    task automatic start_play(input int s);
        @(posedge clk); #1;
        bus.play    = 1'b1;
        bus.seg_sel = 3'(s);
        ctr_restart = 1'b1;
        push_seg(s);
        @(posedge clk); #1;
        bus.play    = 1'b0;
        ctr_restart = 1'b0;
        check("mode", {1'b0, bus.mode}, 32'(s));
        check("prime_en1", {31'd0, bus.addr_en}, 1);
        @(posedge clk); #1;
        check("prime_en2", {31'd0, bus.addr_en}, 1);
        @(posedge clk); #1;
        check("fetch_en", {31'd0, bus.addr_en}, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((bus.busy || sb.size() != 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("timeout", {31'd0, n < 4000}, 1);
        check("end_done", {31'd0, bus.done}, 1);
        check("end_busy", {31'd0, bus.busy}, 0);
    endtask

    initial begin
        bus.play    = 1'b0;
        bus.stop    = 1'b0;
        bus.seg_sel = 3'd0;
        for (int a = 0; a < 64; a++)
            rom[a] = {4'($urandom_range(0, 2)), 12'($urandom_range(0, 5))};
        for (int s = 0; s < 8; s++) begin
            seg_start[s] = s * 8;
            seg_end[s]   = s * 8 + ((s == 3) ? 2 : int'($urandom_range(0, 2)));
        end
        rom[24] = 16'h1003;
        rom[25] = 16'h2000;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", {28'd0, bus.addr_en, bus.buzzer, bus.busy, bus.done}, 0);
        check("rst_note", {16'd0, bus.note}, 0);
        check("rst_mode", {1'b0, bus.mode}, 0);
        rst = 1'b0;

        // Directed segment 3: tone word, rest word, then a random last note.
        start_play(3);
        wait_done();

        // play and stop together in DONE: stop wins.
        @(posedge clk); #1;
        bus.play = 1'b1; bus.stop = 1'b1; bus.seg_sel = 3'd5;
        @(posedge clk); #1;
        bus.play = 1'b0; bus.stop = 1'b0;
        check("ps_ctl", {29'd0, bus.addr_en, bus.busy, bus.done}, 0);
        check("ps_mode", {1'b0, bus.mode}, 3);

        // play while busy is ignored.
        start_play(2);
        repeat (5) @(posedge clk);
        #1;
        bus.play = 1'b1; bus.seg_sel = 3'd6;
        @(posedge clk); #1;
        bus.play = 1'b0;
        check("busy_play_mode", {1'b0, bus.mode}, 2);
        wait_done();

        // stop mid-PLAY.
        start_play(3);
        repeat (10) @(posedge clk);
        #1;
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
        check("stop_ctl", {29'd0, bus.buzzer, bus.busy, bus.done}, 0);
        check("stop_mode", {1'b0, bus.mode}, 3);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("stop_en", {31'd0, bus.addr_en}, 0);
        end

        // Asynchronous reset mid-PLAY, then clean restart.
        start_play(3);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ctl", {28'd0, bus.addr_en, bus.buzzer, bus.busy, bus.done}, 0);
        check("arst_note", {16'd0, bus.note}, 0);
        check("arst_mode", {1'b0, bus.mode}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("arst_idle", {31'd0, bus.busy}, 0);
        start_play(3);
        wait_done();

        for (int i = 0; i < 12; i++) begin
            start_play(int'($urandom_range(0, 7)));
            wait_done();
        end

`ifdef LOOP_PLAY_EN
        begin
            int n;
            int k;
            n = seg_end[1] - seg_start[1] + 1;
            loop = 1'b1;
            start_play(1);
            push_seg(1);
            k = 0;
            while (sb.size() > n - 1 && k < 4000) begin
                @(negedge clk);
                k++;
            end
            check("loop_timeout", {31'd0, k < 4000}, 1);
            loop = 1'b0;
            wait_done();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
